// File: rtl/mux_pkg.sv
// Shared definitions for the stream mux/demux family: channel select codes
// and an elaboration-time ceil(log2) helper.
package mux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // ceil(log2(n)); returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux1to2_if.sv
// Bundle of the demux's input stream, both output channels and the
// per-channel delivered-beat counters.
interface stream_demux1to2_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  // Demux side of the bundle.
  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  // Producer/consumer side of the bundle.
  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy, no push/pop bypass, and a
// read port that keeps showing the last popped word while empty.
module sync_fifo
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_wr, do_rd;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // Full blocks writes even when a pop lands in the same cycle.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the occupancy alone.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = empty ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/stream_demux1to2.sv
// Splits one valid/ready stream into channels a and b by in_sel; each channel
// is buffered independently so a stalled consumer never blocks the other.
module stream_demux1to2
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_demux1to2_if.slave   bus
);

  logic             a_full, a_empty, b_full, b_empty;
  logic             in_ready;
  logic             a_push, b_push, a_pop, b_pop;
  logic [WIDTH-1:0] a_rd_data, b_rd_data;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

  // Ready depends only on the selected channel's fullness, never on x_ready.
  assign in_ready = (bus.in_sel == SEL_B) ? ~b_full : ~a_full;
  assign a_push   = bus.in_valid & in_ready & (bus.in_sel == SEL_A);
  assign b_push   = bus.in_valid & in_ready & (bus.in_sel == SEL_B);
  assign a_pop    = ~a_empty & bus.a_ready;
  assign b_pop    = ~b_empty & bus.b_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (a_push),
    .wr_data (bus.in_data),
    .rd_en   (bus.a_ready),
    .rd_data (a_rd_data),
    .full    (a_full),
    .empty   (a_empty)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (b_push),
    .wr_data (bus.in_data),
    .rd_en   (bus.b_ready),
    .rd_data (b_rd_data),
    .full    (b_full),
    .empty   (b_empty)
  );

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (a_pop) begin
      a_cnt_d = a_cnt_q + CNT_W'(1);
    end
    if (b_pop) begin
      b_cnt_d = b_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.a_valid  = ~a_empty;
  assign bus.a_data   = a_rd_data;
  assign bus.b_valid  = ~b_empty;
  assign bus.b_data   = b_rd_data;
  assign bus.a_count  = a_cnt_q;
  assign bus.b_count  = b_cnt_q;

endmodule
